// File: rtl/gbsha_ttfir_pkg.sv
// Shared constants for the FIR tile driver: FSM encodings, strobe phases and
// the bit layout of the tile's io_in pins.
package gbsha_ttfir_pkg;

    localparam int N_TAPS_DEF   = 4;
    localparam int BW_IN_DEF    = 6;
    localparam int BW_SUM_DEF   = 13;
    localparam int BW_OUT_DEF   = 8;

    localparam int TRST_STROBES = 2;

    localparam int IO_CLK_BIT   = 0;
    localparam int IO_RST_BIT   = 1;
    localparam int IO_X_LSB     = 2;

    typedef logic [2:0] drv_state_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRST    = 3'd1;
    localparam logic [2:0] S_TLSB    = 3'd2;
    localparam logic [2:0] S_TCOEF   = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;
    localparam logic [2:0] S_SAMP_HI = 3'd5;
    localparam logic [2:0] S_SAMP_LO = 3'd6;

    // Tile clock is bit 1 of the phase register, so it comes straight off a flop.
    localparam logic [1:0] PH_IDLE  = 2'b00;
    localparam logic [1:0] PH_SETUP = 2'b01;
    localparam logic [1:0] PH_HIGH  = 2'b10;

endpackage

// File: rtl/gbsha_ttfir_strobe.sv
// Two-cycle tile clock strobe: SETUP (clock low, data settles) then HIGH.
// A 'go' during HIGH chains the next strobe with no idle cycle in between.
module gbsha_ttfir_strobe
    import gbsha_ttfir_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_go,
    output logic o_tclk,
    output logic o_busy,
    output logic o_ready,
    output logic o_capture
);

    logic [1:0] r_phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= PH_IDLE;
        end else if (i_clear) begin
            r_phase <= PH_IDLE;
        end else begin
            case (r_phase)
                PH_IDLE:  if (i_go) r_phase <= PH_SETUP;
                PH_SETUP: r_phase <= PH_HIGH;
                PH_HIGH:  r_phase <= i_go ? PH_SETUP : PH_IDLE;
                default:  r_phase <= PH_IDLE;
            endcase
        end
    end

    assign o_tclk    = r_phase[1];
    assign o_busy    = (r_phase != PH_IDLE);
    assign o_ready   = (r_phase != PH_SETUP);
    assign o_capture = (r_phase == PH_HIGH);

endmodule

// File: rtl/gbsha_ttfir_driver.sv
// Host-side driver for the 8-pin FIR tile: runs tile reset + configuration,
// then streams samples and returns each filter output as a BW_sum-bit word.
module gbsha_ttfir_driver
    import gbsha_ttfir_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_DEF,
    parameter int BW_in  = BW_IN_DEF,
    parameter int BW_sum = BW_SUM_DEF,
    parameter int BW_out = BW_OUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_start,
    input  logic                    cfg_lsb,
    input  logic [N_TAPS*BW_in-1:0] cfg_coef,
    output logic                    cfg_done,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [BW_in-1:0]        s_data,
    output logic                    m_valid,
    output logic [BW_sum-1:0]       m_data,
    output logic [7:0]              fir_io_in,
    input  logic [7:0]              fir_io_out
);

    localparam int CW = $clog2(N_TAPS + TRST_STROBES + 1);

    drv_state_t              r_state;
    logic [CW-1:0]           r_cnt;
    logic                    r_lsb;
    logic [N_TAPS*BW_in-1:0] r_coef;
    logic                    r_io_rst;
    logic [BW_in-1:0]        r_io_x;
    logic [BW_out-1:0]       r_hi;
    logic                    r_m_valid;
    logic [BW_sum-1:0]       r_m_data;

    logic                    w_go;
    logic                    w_go_rst;
    logic [BW_in-1:0]        w_go_x;
    logic [CW-1:0]           w_cfg_total;
    drv_state_t              w_cfg_next;
    logic [BW_in-1:0]        w_coef_sel;
    logic                    w_tclk;
    logic                    w_stb_busy;
    logic                    w_stb_ready;
    logic                    w_capture;
    logic                    w_s_ready;
    logic [7:0]              w_io_in;

    gbsha_ttfir_strobe u_strobe (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_clear   (cfg_start),
        .i_go      (w_go),
        .o_tclk    (w_tclk),
        .o_busy    (w_stb_busy),
        .o_ready   (w_stb_ready),
        .o_capture (w_capture)
    );

    // Coefficients go out highest index first so coef[0] lands last.
    always_comb begin
        w_coef_sel = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            if (r_cnt == CW'(k)) w_coef_sel = r_coef[(N_TAPS-1-k)*BW_in +: BW_in];
        end
    end

    assign w_s_ready = (r_state == S_STREAM) && !w_stb_busy;

    always_comb begin
        w_go        = 1'b0;
        w_go_rst    = r_io_rst;
        w_go_x      = r_io_x;
        w_cfg_total = CW'(N_TAPS);
        w_cfg_next  = S_STREAM;
        case (r_state)
            S_TRST: begin
                w_cfg_total = CW'(TRST_STROBES);
                w_cfg_next  = S_TLSB;
                w_go        = w_stb_ready && (r_cnt < w_cfg_total);
                w_go_rst    = 1'b1;
                w_go_x      = '0;
            end
            S_TLSB: begin
                w_cfg_total = CW'(1);
                w_cfg_next  = S_TCOEF;
                w_go        = w_stb_ready && (r_cnt < w_cfg_total);
                w_go_rst    = 1'b0;
                w_go_x      = '0;
                w_go_x[0]   = r_lsb;
            end
            S_TCOEF: begin
                w_go        = w_stb_ready && (r_cnt < w_cfg_total);
                w_go_rst    = 1'b0;
                w_go_x      = w_coef_sel;
            end
            S_STREAM: begin
                w_go        = s_valid && w_s_ready;
                w_go_rst    = 1'b0;
                w_go_x      = s_data;
            end
            // The shift strobe keeps the same x on the pins.
            S_SAMP_HI: w_go = w_capture && r_lsb;
            default: ;
        endcase
        if (cfg_start) w_go = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lsb     <= 1'b0;
            r_coef    <= '0;
            r_io_rst  <= 1'b1;
            r_io_x    <= '0;
            r_hi      <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (cfg_start) begin
            r_state   <= S_TRST;
            r_cnt     <= '0;
            r_lsb     <= cfg_lsb;
            r_coef    <= cfg_coef;
            r_m_valid <= 1'b0;
        end else begin
            r_m_valid <= 1'b0;
            if (w_go) begin
                r_io_rst <= w_go_rst;
                r_io_x   <= w_go_x;
            end
            case (r_state)
                S_TRST, S_TLSB, S_TCOEF: begin
                    if (w_go) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else if (w_stb_ready && (r_cnt == w_cfg_total)) begin
                        r_cnt   <= '0;
                        r_state <= w_cfg_next;
                    end
                end
                S_STREAM: begin
                    if (w_go) r_state <= S_SAMP_HI;
                end
                S_SAMP_HI: begin
                    if (w_capture) begin
                        if (r_lsb) begin
                            r_hi    <= fir_io_out[BW_out-1:0];
                            r_state <= S_SAMP_LO;
                        end else begin
                            r_m_valid <= 1'b1;
                            r_m_data  <= {fir_io_out[BW_out-1:0], {(BW_sum-BW_out){1'b0}}};
                            r_state   <= S_STREAM;
                        end
                    end
                end
                S_SAMP_LO: begin
                    if (w_capture) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= {r_hi, fir_io_out[BW_sum-BW_out-1:0]};
                        r_state   <= S_STREAM;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_io_in                     = '0;
        w_io_in[IO_CLK_BIT]         = w_tclk;
        w_io_in[IO_RST_BIT]         = r_io_rst;
        w_io_in[IO_X_LSB +: BW_in]  = r_io_x;
    end

    assign fir_io_in = w_io_in;
    assign cfg_done  = (r_state == S_STREAM) || (r_state == S_SAMP_HI) || (r_state == S_SAMP_LO);
    assign s_ready   = w_s_ready;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;

endmodule
